// File: rtl/credit_accumulator_if.sv
// Coin, purchase and change handshake bundle between the credit accumulator
// and its upstream controller / downstream converter and dispenser.
interface credit_accumulator_if;
  logic       coin_nickel;
  logic       coin_dime;
  logic       coin_quarter;
  logic       coin_dollar;
  logic       buy_req;
  logic [8:0] price;
  logic       refund_req;
  logic       change_ack;
  logic [8:0] credit;
  logic [8:0] change;
  logic       change_valid;
  logic       vend_ok;
  logic       vend_denied;
  logic       coin_reject;
  logic       busy;

  modport master (
    output coin_nickel, coin_dime, coin_quarter, coin_dollar,
    output buy_req, price, refund_req, change_ack,
    input  credit, change, change_valid, vend_ok, vend_denied, coin_reject, busy
  );

  modport slave (
    input  coin_nickel, coin_dime, coin_quarter, coin_dollar,
    input  buy_req, price, refund_req, change_ack,
    output credit, change, change_valid, vend_ok, vend_denied, coin_reject, busy
  );
endinterface

// File: rtl/credit_accumulator.sv
// Coin credit accumulator with purchase, refund and change hand-off to the dispenser.
//   state  | meaning
//   IDLE   | accepting coins, purchase and refund requests
//   CHANGE | change/refund offered, waiting for change_ack
module credit_accumulator #(
  parameter int CREDIT_MAX  = 495,
  parameter int VAL_NICKEL  = 5,
  parameter int VAL_DIME    = 10,
  parameter int VAL_QUARTER = 25,
  parameter int VAL_DOLLAR  = 100
) (
  input logic clk,
  input logic reset,
  credit_accumulator_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] CHANGE = 1'b1;

  logic [0:0] state;
  logic [3:0] coin_lvl;
  logic [3:0] coin_prev;
  logic [3:0] coin_edge;
  logic [2:0] n_edge;
  logic [8:0] coin_val;
  logic [9:0] sum10;
  logic       any_edge;
  logic       buy_ok;

  logic [8:0] credit_q;
  logic [8:0] change_q;
  logic       change_valid_q;
  logic       vend_ok_q;
  logic       vend_denied_q;
  logic       coin_reject_q;

  assign coin_lvl  = {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel};
  assign coin_edge = coin_lvl & ~coin_prev;
  assign any_edge  = |coin_edge;
  assign buy_ok    = (bus.price != 9'd0) && (credit_q >= bus.price);

  always_comb begin
    n_edge   = '0;
    coin_val = '0;
    for (int i = 0; i < 4; i++) begin
      if (coin_edge[i]) n_edge = n_edge + 3'd1;
    end
    // only meaningful when exactly one edge is present
    if (coin_edge[0])      coin_val = 9'(VAL_NICKEL);
    else if (coin_edge[1]) coin_val = 9'(VAL_DIME);
    else if (coin_edge[2]) coin_val = 9'(VAL_QUARTER);
    else if (coin_edge[3]) coin_val = 9'(VAL_DOLLAR);
  end

  assign sum10 = {1'b0, credit_q} + {1'b0, coin_val};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      coin_prev      <= 4'b1111;
      credit_q       <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      vend_ok_q      <= 1'b0;
      vend_denied_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      coin_prev     <= coin_lvl;
      vend_ok_q     <= 1'b0;
      vend_denied_q <= 1'b0;
      coin_reject_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.buy_req) begin
            coin_reject_q <= any_edge;
            if (buy_ok) begin
              vend_ok_q <= 1'b1;
              credit_q  <= '0;
              change_q  <= credit_q - bus.price;
              if (credit_q != bus.price) begin
                change_valid_q <= 1'b1;
                state          <= CHANGE;
              end
            end else begin
              vend_denied_q <= 1'b1;
            end
          end else if (bus.refund_req && (credit_q != 9'd0)) begin
            coin_reject_q  <= any_edge;
            change_q       <= credit_q;
            credit_q       <= '0;
            change_valid_q <= 1'b1;
            state          <= CHANGE;
          end else if (n_edge == 3'd1) begin
            if (sum10 <= 10'(CREDIT_MAX)) credit_q <= sum10[8:0];
            else                          coin_reject_q <= 1'b1;
          end else if (n_edge > 3'd1) begin
            coin_reject_q <= 1'b1;
          end
        end
        CHANGE: begin
          coin_reject_q <= any_edge;
          if (bus.change_ack) begin
            change_valid_q <= 1'b0;
            change_q       <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.credit       = credit_q;
  assign bus.change       = change_q;
  assign bus.change_valid = change_valid_q;
  assign bus.vend_ok      = vend_ok_q;
  assign bus.vend_denied  = vend_denied_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = (state == CHANGE);

endmodule

// File: tb/tb_credit_accumulator.sv
// Directed plus randomized bench for credit_accumulator; every output is checked
// each cycle against a behavioural credit/change model.
module tb_credit_accumulator;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  credit_accumulator_if bus ();

  credit_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // behavioural model state
  int         m_credit, m_change;
  bit         m_pend, m_ok, m_den, m_rej;
  bit  [3:0]  m_prev;
  int         coin_vals [4] = '{5, 10, 25, 100};
  bit  [3:0]  lvl_now;
  int         n_new, new_val;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lvl(input bit [3:0] l);
    bus.coin_nickel  = l[0];
    bus.coin_dime    = l[1];
    bus.coin_quarter = l[2];
    bus.coin_dollar  = l[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // model update at the sampling edge, compare once outputs have settled
  always @(posedge clk) begin
    lvl_now = {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel};
    n_new = 0; new_val = 0;
    for (int i = 0; i < 4; i++)
      if (lvl_now[i] && !m_prev[i]) begin n_new++; new_val = coin_vals[i]; end
    m_ok = 0; m_den = 0; m_rej = 0;
    if (reset) begin
      m_credit = 0; m_change = 0; m_pend = 0; lvl_now = 4'b1111;
    end else if (m_pend) begin
      m_rej = (n_new > 0);
      if (bus.change_ack) begin m_pend = 0; m_change = 0; end
    end else if (bus.buy_req) begin
      m_rej = (n_new > 0);
      if (bus.price != 0 && m_credit >= int'(bus.price)) begin
        m_ok = 1;
        m_change = m_credit - int'(bus.price);
        m_credit = 0;
        m_pend = (m_change > 0);
      end else m_den = 1;
    end else if (bus.refund_req && m_credit > 0) begin
      m_rej = (n_new > 0);
      m_change = m_credit; m_credit = 0; m_pend = 1;
    end else if (n_new == 1) begin
      if (m_credit + new_val <= 495) m_credit += new_val;
      else m_rej = 1;
    end else if (n_new > 1) m_rej = 1;
    m_prev = lvl_now;
    #1;
    check("credit",       int'(bus.credit),       m_credit);
    check("change",       int'(bus.change),       m_change);
    check("change_valid", int'(bus.change_valid), int'(m_pend));
    check("vend_ok",      int'(bus.vend_ok),      int'(m_ok));
    check("vend_denied",  int'(bus.vend_denied),  int'(m_den));
    check("coin_reject",  int'(bus.coin_reject),  int'(m_rej));
    check("busy",         int'(bus.busy),         int'(m_pend));
  end

  // pulse one coin input high for a cycle, then check credit and reject
  task automatic coin_in(input int idx, input int exp_credit, input bit exp_rej);
    bit [3:0] l;
    l = '0;
    l[idx] = 1'b1;
    set_lvl(l);
    tick();
    check("lit_coin_credit", int'(bus.credit), exp_credit);
    check("lit_coin_reject", int'(bus.coin_reject), int'(exp_rej));
    set_lvl(4'b0000);
    tick();
  endtask

  task automatic pay_back();
    bus.refund_req = 1'b1; tick(); bus.refund_req = 1'b0;
    bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    set_lvl(4'b0100);
    bus.buy_req = 1'b0; bus.price = '0; bus.refund_req = 1'b0; bus.change_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("lit_reset_credit", int'(bus.credit), 0);
    check("lit_reset_busy", int'(bus.busy), 0);
    check("lit_reset_cv", int'(bus.change_valid), 0);
    set_lvl(4'b0000);
    tick();

    // accumulation, long-held coin counts once
    coin_in(2, 25, 0); tick();
    coin_in(1, 35, 0); tick();
    coin_in(0, 40, 0);
    set_lvl(4'b0100);
    repeat (10) tick();
    check("lit_held_quarter", int'(bus.credit), 65);
    set_lvl(4'b0000); tick();

    // purchase with change
    coin_in(3, 165, 0);
    coin_in(1, 175, 0);
    bus.price = 9'd150; bus.buy_req = 1'b1; tick(); bus.buy_req = 1'b0;
    check("lit_buy_ok", int'(bus.vend_ok), 1);
    check("lit_buy_credit", int'(bus.credit), 0);
    check("lit_buy_change", int'(bus.change), 25);
    check("lit_buy_cv", int'(bus.change_valid), 1);
    check("lit_buy_busy", int'(bus.busy), 1);
    repeat (5) tick();
    check("lit_hold_change", int'(bus.change), 25);
    bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
    check("lit_ack_cv", int'(bus.change_valid), 0);
    check("lit_ack_busy", int'(bus.busy), 0);

    // denied purchases and exact purchase
    coin_in(3, 100, 0);
    bus.price = 9'd125; bus.buy_req = 1'b1; tick(); bus.buy_req = 1'b0;
    check("lit_deny_price", int'(bus.vend_denied), 1);
    check("lit_deny_credit", int'(bus.credit), 100);
    bus.price = 9'd0; bus.buy_req = 1'b1; tick(); bus.buy_req = 1'b0;
    check("lit_deny_zero", int'(bus.vend_denied), 1);
    bus.price = 9'd100; bus.buy_req = 1'b1; tick(); bus.buy_req = 1'b0;
    check("lit_exact_ok", int'(bus.vend_ok), 1);
    check("lit_exact_cv", int'(bus.change_valid), 0);
    tick();

    // saturation at the credit ceiling
    for (int i = 1; i <= 4; i++) coin_in(3, 100 * i, 0);
    coin_in(2, 425, 0); coin_in(2, 450, 0); coin_in(2, 475, 0);
    coin_in(1, 485, 0); coin_in(0, 490, 0);
    coin_in(0, 495, 0);
    coin_in(0, 495, 1);
    pay_back();
    for (int i = 1; i <= 4; i++) coin_in(3, 100 * i, 0);
    coin_in(3, 400, 1);
    pay_back();

    // simultaneous coins, buy with coin
    coin_in(2, 25, 0);
    set_lvl(4'b0110); tick();
    check("lit_dual_reject", int'(bus.coin_reject), 1);
    check("lit_dual_credit", int'(bus.credit), 25);
    set_lvl(4'b0000); tick();
    check("lit_dual_single", int'(bus.coin_reject), 0);
    coin_in(2, 50, 0);
    bus.price = 9'd50; bus.buy_req = 1'b1; set_lvl(4'b0001); tick();
    bus.buy_req = 1'b0; set_lvl(4'b0000);
    check("lit_buycoin_ok", int'(bus.vend_ok), 1);
    check("lit_buycoin_rej", int'(bus.coin_reject), 1);
    check("lit_buycoin_credit", int'(bus.credit), 0);
    tick();

    // refund, coin during CHANGE, reset before ack
    coin_in(2, 25, 0); coin_in(2, 50, 0); coin_in(1, 60, 0); coin_in(0, 65, 0);
    bus.refund_req = 1'b1; tick(); bus.refund_req = 1'b0;
    check("lit_refund_change", int'(bus.change), 65);
    check("lit_refund_cv", int'(bus.change_valid), 1);
    coin_in(1, 0, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("lit_rst_credit", int'(bus.credit), 0);
    check("lit_rst_change", int'(bus.change), 0);
    check("lit_rst_cv", int'(bus.change_valid), 0);
    check("lit_rst_busy", int'(bus.busy), 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit [3:0] l;
      l = {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel};
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) l[b] = ~l[b];
      set_lvl(l);
      bus.buy_req    = ($urandom_range(0, 11) == 0);
      bus.price      = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511))
                                                   : 9'($urandom_range(0, 40) * 5);
      bus.refund_req = ($urandom_range(0, 19) == 0);
      bus.change_ack = ($urandom_range(0, 3) == 0);
      reset          = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/credit_accumulator.md
Name: credit_accumulator

Overview:
Upstream feeder of the cents-to-coin-digit converter. Edge-detects coin-insert inputs and accumulates customer credit in cents; its registered credit output drives the converter's 9-bit cents input.
Handles purchase against a price: grants or denies the vend, computes change, and offers change or refund to the downstream dispenser via a valid/ack handshake.

Parameters:
CREDIT_MAX, 495, maximum credit in cents; multiple of 5, at most 511
VAL_NICKEL / VAL_DIME / VAL_QUARTER / VAL_DOLLAR, 5 / 10 / 25 / 100, coin values in cents

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
coin_nickel / coin_dime / coin_quarter / coin_dollar  in  1 each  synchronized coin-sensor levels; a rising edge is one coin
buy_req  in  1  purchase request, sampled every cycle
price  in  9  item price in cents, sampled with buy_req
refund_req  in  1  return all credit
change_ack  in  1  dispenser has taken the change value
credit  out  9  current credit in cents, to the converter
change  out  9  change/refund amount in cents, valid while change_valid
change_valid  out  1  change offer pending
vend_ok  out  1  one-cycle pulse, purchase granted
vend_denied  out  1  one-cycle pulse, purchase refused
coin_reject  out  1  one-cycle pulse, inserted coin not credited (mechanism returns it)
busy  out  1  high when state is not IDLE

Behaviour:
- All outputs registered; every response appears exactly 1 cycle after the sampling edge.
- Reset values: credit=0, change=0, change_valid=0, pulses=0, busy=0, state=IDLE, coin edge-detect history=1.
  - A coin input held high through reset does not credit; it must go low then high.
- Edge detect: per coin, edge = level & ~prev; prev updates every cycle. A level held high for N cycles counts once.
- States: IDLE, CHANGE.
- IDLE, same-cycle priority is buy_req > refund_req > coin edge:
  - buy_req, price!=0, credit>=price: vend_ok=1; credit<=0; change<=credit-price.
    - If the difference is >0: change_valid<=1, go CHANGE. Otherwise stay IDLE.
  - buy_req, price==0 or credit<price: vend_denied=1; credit unchanged.
  - refund_req, credit>0: change<=credit, credit<=0, change_valid<=1, go CHANGE.
  - refund_req, credit==0: no effect.
  - Exactly one coin edge, no buy/refund: if credit+value<=CREDIT_MAX, credit+=value; else coin_reject=1.
  - Two or more coin edges in one cycle: none credited; coin_reject=1 (single pulse).
  - Coin edge in the same cycle as an accepted buy_req or refund_req: coin_reject=1.
- CHANGE:
  - change and change_valid held stable until change_ack=1.
  - On change_ack: next cycle change_valid=0, change=0, state IDLE.
  - buy_req and refund_req ignored (no pulses).
  - Every coin edge gives coin_reject=1; credit stays 0.
- change_ack in IDLE is ignored.
- Arithmetic: 10-bit internal sum for the overflow compare; credit never exceeds CREDIT_MAX and never wraps.
- Reset mid-CHANGE: pending change discarded; all outputs return to reset values next cycle.

Test Plan:
1. After reset, quarter, dime, nickel edges 3 cycles apart -> credit 25, 35, 40; quarter held high 10 cycles -> credit 65 only.
2. Credit 175, price=150, buy_req -> vend_ok pulse, credit 0, change 25, change_valid=1, busy=1; ack after 5 cycles -> change_valid 0, state IDLE.
3. Credit 100, price=125, buy_req -> vend_denied pulse, credit stays 100. Price=0 -> vend_denied. Credit 100, price=100 -> vend_ok, change_valid stays 0.
4. Credit 490, nickel -> 495; second nickel -> coin_reject, credit 495. Credit 400, dollar -> coin_reject.
5. Quarter and dime edges in the same cycle -> one coin_reject pulse, credit unchanged. Buy_req plus nickel edge with credit 50, price 50 -> vend_ok and coin_reject together, credit 0.
6. Credit 65, refund_req -> change 65, change_valid=1. Dime during CHANGE -> coin_reject. Reset asserted before ack -> credit, change, change_valid, busy all 0 next cycle.
